sequenciador_genius: RTL

//  Control unit of the Genius memory game with difficulty selection.

---
 rtl/sequenciador_genius_pkg.sv | 28 ++
 rtl/sequenciador_genius_contador_m.sv | 34 +++
 rtl/sequenciador_genius.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sequenciador_genius_pkg.sv
// Shared definitions for the Genius memory game control unit:
// state codes, last round for the easy level and LED width.
package sequenciador_genius_pkg;

   typedef enum logic [3:0] {
      INICIAL     = 4'h0,
      PREPARA     = 4'h1,
      MOSTRA      = 4'h2,
      INTERVALO   = 4'h3,
      PROX_MOSTRA = 4'h4,
      ESPERA      = 4'h5,
      REGISTRA    = 4'h6,
      COMPARA     = 4'h7,
      PROX_JOGADA = 4'h8,
      PROX_RODADA = 4'h9,
      GANHOU      = 4'hA,
      PERDEU      = 4'hB
   } estado_t;

   localparam int ULTIMA_NIVEL0 = 7;
   localparam int LED_W         = 4;

   // Width of a modulo-M counter; never below one bit.
   function automatic int f_largura(input int m);
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/sequenciador_genius_contador_m.sv
// Modulo-M up counter with synchronous clear; fim flags the terminal count M-1.
module contador_m #(
   parameter int M = 100,
   parameter int N = 7
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         zera,
   input  logic         conta,
   output logic [N-1:0] Q,
   output logic         fim
);

   logic [N-1:0] r_q;

   // Count register: clear wins over count, wraps after M-1.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_q <= {N{1'b0}};
      end else if (zera) begin
         r_q <= {N{1'b0}};
      end else if (conta) begin
         if (r_q == N'(M - 1)) begin
            r_q <= {N{1'b0}};
         end else begin
            r_q <= r_q + N'(1);
         end
      end
   end

   assign Q   = r_q;
   assign fim = (r_q == N'(M - 1));

endmodule

// File: rtl/sequenciador_genius.sv
// Genius memory game control unit: shows the stored sequence, waits for plays, counts rounds.
// Optional play timeout enabled by defining TIMEOUT_EN.
module sequenciador_genius
   import sequenciador_genius_pkg::*;
#(
   parameter int N_RODADAS   = 16,
   parameter int ADDR_W      = 4,
   parameter int T_MOSTRA    = 500,
   parameter int T_INTERVALO = 250,
   parameter int T_TIMEOUT   = 5000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              iniciar,
   input  logic              nivel,
   input  logic              tem_jogada,
   input  logic              jogada_correta,
   input  logic [LED_W-1:0]  mem_dado,
   output logic [ADDR_W-1:0] mem_endereco,
   output logic              registra_jogada,
   output logic [LED_W-1:0]  leds,
   output logic              pronto,
   output logic              ganhou,
   output logic              perdeu,
   output logic              db_timeout,
   output logic [ADDR_W-1:0] db_rodada,
   output logic [3:0]        db_estado
);

   localparam int W_MOSTRA    = f_largura(T_MOSTRA);
   localparam int W_INTERVALO = f_largura(T_INTERVALO);
   localparam logic [ADDR_W-1:0] ULTIMA_FACIL   = ADDR_W'(ULTIMA_NIVEL0);
   localparam logic [ADDR_W-1:0] ULTIMA_DIFICIL = ADDR_W'(N_RODADAS - 1);

   estado_t           r_estado;
   estado_t           w_prox;
   logic [ADDR_W-1:0] r_endereco;
   logic [ADDR_W-1:0] r_rodada;
   logic              r_nivel;
   logic [ADDR_W-1:0] w_ultima;

   logic w_inicia;
   logic w_inc_end;
   logic w_zera_end;
   logic w_inc_rod;

   logic [W_MOSTRA-1:0]    w_q_mostra;
   logic [W_INTERVALO-1:0] w_q_intervalo;
   logic                   w_fim_mostra;
   logic                   w_fim_intervalo;

   // Each phase timer is held at zero outside its own state, so entry always starts a full period.
   contador_m #(.M(T_MOSTRA), .N(W_MOSTRA)) u_tmr_mostra (
      .clock (clock),
      .reset (reset),
      .zera  (r_estado != MOSTRA),
      .conta (r_estado == MOSTRA),
      .Q     (w_q_mostra),
      .fim   (w_fim_mostra)
   );

   contador_m #(.M(T_INTERVALO), .N(W_INTERVALO)) u_tmr_intervalo (
      .clock (clock),
      .reset (reset),
      .zera  (r_estado != INTERVALO),
      .conta (r_estado == INTERVALO),
      .Q     (w_q_intervalo),
      .fim   (w_fim_intervalo)
   );

`ifdef TIMEOUT_EN
   localparam int W_TIMEOUT = f_largura(T_TIMEOUT);
   logic [W_TIMEOUT-1:0] w_q_timeout;
   logic                 w_fim_timeout;
   logic                 w_set_timeout;
   logic                 r_timeout;
   logic                 w_unused_q;

   contador_m #(.M(T_TIMEOUT), .N(W_TIMEOUT)) u_tmr_timeout (
      .clock (clock),
      .reset (reset),
      .zera  (r_estado != ESPERA),
      .conta (r_estado == ESPERA),
      .Q     (w_q_timeout),
      .fim   (w_fim_timeout)
   );

   assign w_unused_q = ^{w_q_mostra, w_q_intervalo, w_q_timeout};

   // Remembers that the current loss came from the play timeout.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_timeout <= 1'b0;
      end else if (r_estado == PREPARA) begin
         r_timeout <= 1'b0;
      end else if (w_set_timeout) begin
         r_timeout <= 1'b1;
      end
   end
`else
   localparam int unused_t_timeout = T_TIMEOUT;
   logic w_unused_q;
   assign w_unused_q = ^{w_q_mostra, w_q_intervalo};
`endif

   assign w_ultima = r_nivel ? ULTIMA_DIFICIL : ULTIMA_FACIL;

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_estado <= INICIAL;
      end else begin
         r_estado <= w_prox;
      end
   end

   // Next-state logic and counter control strobes.
   always_comb begin
      w_prox     = r_estado;
      w_inicia   = 1'b0;
      w_inc_end  = 1'b0;
      w_zera_end = 1'b0;
      w_inc_rod  = 1'b0;
`ifdef TIMEOUT_EN
      w_set_timeout = 1'b0;
`endif
      case (r_estado)
         INICIAL, GANHOU, PERDEU: begin
            if (iniciar) begin
               w_prox   = PREPARA;
               w_inicia = 1'b1;
            end else begin
               w_prox = r_estado;
            end
         end
         PREPARA: w_prox = MOSTRA;
         MOSTRA: begin
            if (w_fim_mostra) begin
               if (r_endereco == r_rodada) begin
                  w_prox     = ESPERA;
                  w_zera_end = 1'b1;
               end else begin
                  w_prox = INTERVALO;
               end
            end else begin
               w_prox = MOSTRA;
            end
         end
         INTERVALO: begin
            if (w_fim_intervalo) begin
               w_prox = PROX_MOSTRA;
            end else begin
               w_prox = INTERVALO;
            end
         end
         PROX_MOSTRA: begin
            w_inc_end = 1'b1;
            w_prox    = MOSTRA;
         end
         // A play arriving on the expiry cycle still counts.
         ESPERA: begin
            if (tem_jogada) begin
               w_prox = REGISTRA;
            end
`ifdef TIMEOUT_EN
            else if (w_fim_timeout) begin
               w_prox        = PERDEU;
               w_set_timeout = 1'b1;
            end
`endif
            else begin
               w_prox = ESPERA;
            end
         end
         REGISTRA: w_prox = COMPARA;
         COMPARA: begin
            if (!jogada_correta) begin
               w_prox = PERDEU;
            end else if (r_endereco < r_rodada) begin
               w_prox = PROX_JOGADA;
            end else if (r_rodada == w_ultima) begin
               w_prox = GANHOU;
            end else begin
               w_prox = PROX_RODADA;
            end
         end
         PROX_JOGADA: begin
            w_inc_end = 1'b1;
            w_prox    = ESPERA;
         end
         PROX_RODADA: begin
            w_inc_rod  = 1'b1;
            w_zera_end = 1'b1;
            w_prox     = MOSTRA;
         end
         default: w_prox = INICIAL;
      endcase
   end

   // Address and round counters plus the level latched at game start.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_endereco <= {ADDR_W{1'b0}};
         r_rodada   <= {ADDR_W{1'b0}};
         r_nivel    <= 1'b0;
      end else if (w_inicia) begin
         r_endereco <= {ADDR_W{1'b0}};
         r_rodada   <= {ADDR_W{1'b0}};
         r_nivel    <= nivel;
      end else begin
         if (w_zera_end) begin
            r_endereco <= {ADDR_W{1'b0}};
         end else if (w_inc_end) begin
            r_endereco <= r_endereco + ADDR_W'(1);
         end
         if (w_inc_rod) begin
            r_rodada <= r_rodada + ADDR_W'(1);
         end
      end
   end

   // Moore output decode from the registered state and counters.
   always_comb begin
      mem_endereco    = r_endereco;
      db_rodada       = r_rodada;
      db_estado       = r_estado;
      registra_jogada = (r_estado == REGISTRA);
      pronto          = (r_estado == GANHOU) || (r_estado == PERDEU);
      ganhou          = (r_estado == GANHOU);
      perdeu          = (r_estado == PERDEU);
      if (r_estado == MOSTRA) begin
         leds = mem_dado;
      end else begin
         leds = {LED_W{1'b0}};
      end
`ifdef TIMEOUT_EN
      db_timeout = (r_estado == PERDEU) && r_timeout;
`else
      db_timeout = 1'b0;
`endif
   end

endmodule
